// File: rtl/cwc_capture_ctrl_if.sv
// Signal bundle between the capture sequencer and its control, probe, sample-RAM and readout neighbours.
// The master modport is the sequencer side and the slave modport is the environment side.
interface cwc_capture_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic              arm;
    logic              abort;
    logic [ADDR_W-1:0] pre_trig;
    logic [DATA_W-1:0] trig_mask;
    logic [DATA_W-1:0] trig_value;
    logic              sample_en;
    logic [DATA_W-1:0] probe;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_rdata;
    logic              rd_start;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              triggered;
    logic              done;
    logic [ADDR_W-1:0] trig_addr;

    modport master (
        input  arm, abort, pre_trig, trig_mask, trig_value, sample_en, probe,
        input  ram_rdata, rd_start, out_ready,
        output ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr,
        output out_valid, out_data, out_last, busy, triggered, done, trig_addr
    );

    modport slave (
        output arm, abort, pre_trig, trig_mask, trig_value, sample_en, probe,
        output ram_rdata, rd_start, out_ready,
        input  ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr,
        input  out_valid, out_data, out_last, busy, triggered, done, trig_addr
    );
endinterface

// File: rtl/cwc_capture_ctrl.sv
// Capture sequencer: pre-trigger ring fill, mask/value trigger, post fill, then in-order playback of the window.
// RAM writes follow sample_en in the same cycle; readout has one cycle of RAM latency and stops issuing while out_valid && !out_ready.
module cwc_capture_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input logic                i_clk,
    input logic                i_rst,
    cwc_capture_ctrl_if.master io_bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_WAIT_TRIG, S_POST, S_DONE, S_READ
    } state_t;

    localparam logic [ADDR_W-1:0] LP_MAX   = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LP_LAST  = (ADDR_W + 1)'(DEPTH - 1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_pre;
    logic [ADDR_W-1:0] r_trig_addr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_issued;
    logic [DATA_W-1:0] r_mask;
    logic [DATA_W-1:0] r_value;
    logic              r_trig;
    logic              r_out_valid;
    logic              r_out_last;

    logic              w_capturing;
    logic              w_we;
    logic              w_hit;
    logic              w_re;
    logic              w_hs;
    logic              w_arm_ok;
    logic              w_rd_go;
    logic              w_busy;
    logic              w_done;
    logic [ADDR_W-1:0] w_cnt_inc;
    logic [ADDR_W-1:0] w_post_len;
    logic [ADDR_W-1:0] w_pre_clip;

    assign w_capturing = (r_state == S_PRE) || (r_state == S_WAIT_TRIG) || (r_state == S_POST);
    assign w_we        = w_capturing && io_bus.sample_en && !io_bus.abort;
    assign w_hit       = (r_state == S_WAIT_TRIG) && w_we &&
                         (((io_bus.probe ^ r_value) & r_mask) == '0);
    assign w_cnt_inc   = r_cnt + 1'b1;
    assign w_post_len  = LP_MAX - r_pre;
    assign w_pre_clip  = (io_bus.pre_trig > LP_MAX) ? LP_MAX : io_bus.pre_trig;
    assign w_arm_ok    = io_bus.arm && !io_bus.abort &&
                         ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_rd_go     = (r_state == S_DONE) && io_bus.rd_start && !io_bus.arm && !io_bus.abort;
    // Issue only when the output slot is free or being drained, so ram_rdata never changes under a stall.
    assign w_re        = (r_state == S_READ) && !io_bus.abort &&
                         (!r_out_valid || io_bus.out_ready) && (r_issued < LP_DEPTH);
    assign w_hs        = r_out_valid && io_bus.out_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_busy = (r_state != S_IDLE) && (r_state != S_DONE);
        w_done = (r_state == S_DONE);
        if (io_bus.abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_arm_ok)     w_next = (w_pre_clip == '0) ? S_WAIT_TRIG : S_PRE;
                    else if (w_rd_go) w_next = S_READ;
                end
                S_PRE:       if (w_we && (w_cnt_inc == r_pre)) w_next = S_WAIT_TRIG;
                S_WAIT_TRIG: if (w_hit) w_next = (w_post_len == '0) ? S_DONE : S_POST;
                S_POST:      if (w_we && (w_cnt_inc == w_post_len)) w_next = S_DONE;
                S_READ:      if (w_hs && r_out_last) w_next = S_DONE;
                default:     w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr      <= '0;
            r_cnt       <= '0;
            r_pre       <= '0;
            r_trig_addr <= '0;
            r_rptr      <= '0;
            r_issued    <= '0;
            r_mask      <= '0;
            r_value     <= '0;
            r_trig      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (io_bus.abort) begin
            r_trig      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_arm_ok) begin
                r_pre   <= w_pre_clip;
                r_mask  <= io_bus.trig_mask;
                r_value <= io_bus.trig_value;
                r_trig  <= 1'b0;
                r_wptr  <= '0;
                r_cnt   <= '0;
            end
            if (w_we) begin
                r_wptr <= r_wptr + 1'b1;
                r_cnt  <= w_cnt_inc;
            end
            // The post-trigger count starts from the trigger sample itself.
            if (w_hit) begin
                r_trig_addr <= r_wptr;
                r_trig      <= 1'b1;
                r_cnt       <= '0;
            end
            if (w_rd_go) begin
                r_rptr   <= r_trig_addr - r_pre;
                r_issued <= '0;
            end
            if (w_re) begin
                r_rptr      <= r_rptr + 1'b1;
                r_issued    <= r_issued + 1'b1;
                r_out_valid <= 1'b1;
                r_out_last  <= (r_issued == LP_LAST);
            end else if (w_hs) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign io_bus.ram_we    = w_we;
    assign io_bus.ram_waddr = r_wptr;
    assign io_bus.ram_wdata = w_we ? io_bus.probe : '0;
    assign io_bus.ram_re    = w_re;
    assign io_bus.ram_raddr = r_rptr;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_data  = r_out_valid ? io_bus.ram_rdata : '0;
    assign io_bus.out_last  = r_out_last;
    assign io_bus.busy      = w_busy;
    assign io_bus.triggered = r_trig;
    assign io_bus.done      = w_done;
    assign io_bus.trig_addr = r_trig_addr;
endmodule

// File: tb/tb_cwc_capture_ctrl.sv
// Bench for cwc_capture_ctrl at DEPTH=16: randomized capture/readout scenarios against a sample-stream window model.
module tb_cwc_capture_ctrl;
    localparam int DW = 32;
    localparam int DEPTH = 16;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cwc_capture_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    cwc_capture_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .io_bus(bus)
    );

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
        if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_raddr];
    end

    int n_checks = 0;
    int n_pass = 0;
    logic [DW-1:0] stream[$];
    logic [DW-1:0] rd_q[$];

    // Index in the written stream of the first matching sample at or after the pre-window.
    function automatic int model_trig(input int pre, input logic [DW-1:0] mask, input logic [DW-1:0] value);
        for (int i = pre; i < stream.size(); i++)
            if (((stream[i] ^ value) & mask) == '0) return i;
        return -1;
    endfunction

    function automatic int window_errs(input int t, input int pre);
        int bad = 0;
        if (t < 0) return DEPTH;
        for (int k = 0; k < DEPTH; k++)
            if (k >= rd_q.size() || (t - pre + k) >= stream.size() || rd_q[k] !== stream[t - pre + k]) bad++;
        return bad;
    endfunction

    task automatic idle_inputs();
        bus.arm = 0; bus.abort = 0; bus.pre_trig = '0; bus.trig_mask = '0; bus.trig_value = '0;
        bus.sample_en = 0; bus.probe = '0; bus.rd_start = 0; bus.out_ready = 0;
    endtask

    task automatic arm_cap(input int pre, input logic [DW-1:0] mask, input logic [DW-1:0] value);
        @(negedge clk);
        bus.arm = 1; bus.pre_trig = AW'(pre); bus.trig_mask = mask; bus.trig_value = value;
        @(negedge clk);
        bus.arm = 0;
    endtask

    // en_mode: 0 always, 1 alternate, 2 random. Probe is a per-cycle counter.
    task automatic feed(input int en_mode, input logic [DW-1:0] start, output int we_err, output bit tmo);
        logic [DW-1:0] v;
        bit en;
        v = start; we_err = 0; tmo = 1; stream.delete();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin tmo = 0; break; end
            case (en_mode)
                0: en = 1;
                1: en = (c % 2 == 0);
                default: en = ($urandom_range(0, 1) == 1);
            endcase
            bus.sample_en = en; bus.probe = v;
            #1;
            if (bus.ram_we !== en) we_err++;
            else if (en && (bus.ram_wdata !== v || bus.ram_waddr !== AW'(stream.size() % DEPTH))) we_err++;
            if (en) stream.push_back(v);
            v = v + 1;
        end
        bus.sample_en = 0;
    endtask

    task automatic read_window(input int ready_pct, output int nlast, output int last_idx,
                               output int stall_err, output int cycles, output bit tmo);
        logic [DW-1:0] hold;
        bit stalled;
        rd_q.delete(); nlast = 0; last_idx = -1; stall_err = 0; cycles = 0; tmo = 1; stalled = 0; hold = '0;
        @(negedge clk); bus.rd_start = 1;
        @(negedge clk); bus.rd_start = 0;
        for (int c = 0; c < 2000; c++) begin
            if (bus.done === 1'b1) begin tmo = 0; break; end
            bus.out_ready = ($urandom_range(0, 99) < ready_pct);
            #1;
            if (stalled && (bus.out_valid !== 1'b1 || bus.out_data !== hold)) stall_err++;
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                rd_q.push_back(bus.out_data);
                if (bus.out_last === 1'b1) begin nlast++; last_idx = rd_q.size() - 1; end
            end
            stalled = (bus.out_valid === 1'b1) && !bus.out_ready;
            hold = bus.out_data;
            cycles++;
            @(negedge clk);
        end
        bus.out_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs();
        bus.sample_en = 1; bus.probe = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if ({bus.busy, bus.done, bus.triggered, bus.ram_we, bus.ram_re, bus.out_valid, bus.out_last} !== 7'b0)
            $display("FAIL reset_flags: got %b expected 0", {bus.busy, bus.done, bus.triggered, bus.ram_we, bus.ram_re, bus.out_valid, bus.out_last}); else n_pass++;
        n_checks++; if ({bus.trig_addr, bus.ram_waddr, bus.ram_raddr} !== '0)
            $display("FAIL reset_addrs: got %h expected 0", {bus.trig_addr, bus.ram_waddr, bus.ram_raddr}); else n_pass++;
        n_checks++; if ({bus.ram_wdata, bus.out_data} !== '0)
            $display("FAIL reset_data: got %h expected 0", {bus.ram_wdata, bus.out_data}); else n_pass++;
        bus.sample_en = 0; bus.probe = '0;
        @(negedge clk); rst = 0;
    endtask

    task automatic test_basic_trigger();
        int we_err, t, nlast, lidx, serr, cyc; bit tmo, rtmo;
        arm_cap(4, 32'hFFFF_FFFF, 32'h20);
        n_checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) $display("FAIL basic_busy: got %b%b expected 10", bus.busy, bus.done); else n_pass++;
        feed(0, 32'h10, we_err, tmo);
        t = model_trig(4, 32'hFFFF_FFFF, 32'h20);
        n_checks++; if (tmo) $display("FAIL basic_done_timeout: got no done expected done"); else n_pass++;
        n_checks++; if (we_err != 0) $display("FAIL basic_writes: got %0d bad writes expected 0", we_err); else n_pass++;
        n_checks++; if (stream.size() != t + DEPTH - 4) $display("FAIL basic_len: got %0d expected %0d", stream.size(), t + DEPTH - 4); else n_pass++;
        n_checks++; if (bus.triggered !== 1'b1) $display("FAIL basic_triggered: got %b expected 1", bus.triggered); else n_pass++;
        n_checks++; if (bus.trig_addr !== AW'(t % DEPTH)) $display("FAIL basic_trig_addr: got %0d expected %0d", bus.trig_addr, t % DEPTH); else n_pass++;
        read_window(100, nlast, lidx, serr, cyc, rtmo);
        n_checks++; if (rtmo || window_errs(t, 4) != 0) $display("FAIL basic_window: got %0d bad words expected 0", window_errs(t, 4)); else n_pass++;
        n_checks++; if (rd_q.size() != DEPTH || rd_q[0] !== 32'h1C || rd_q[DEPTH-1] !== 32'h2B)
            $display("FAIL basic_ends: got %0d words first %h last %h expected 16 1c 2b", rd_q.size(), rd_q[0], rd_q[rd_q.size()-1]); else n_pass++;
        n_checks++; if (nlast != 1 || lidx != DEPTH - 1) $display("FAIL basic_last: got %0d at %0d expected 1 at %0d", nlast, lidx, DEPTH - 1); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int nlast, lidx, serr, cyc, t; bit rtmo;
        t = model_trig(4, 32'hFFFF_FFFF, 32'h20);
        read_window(100, nlast, lidx, serr, cyc, rtmo);
        n_checks++; if (rtmo || cyc != DEPTH + 1) $display("FAIL b2b_cycles: got %0d expected %0d", cyc, DEPTH + 1); else n_pass++;
        n_checks++; if (window_errs(t, 4) != 0) $display("FAIL b2b_reread: got %0d bad words expected 0", window_errs(t, 4)); else n_pass++;
    endtask

    task automatic test_mask_zero();
        int we_err, t, nlast, lidx, serr, cyc; bit tmo, rtmo;
        arm_cap(0, 32'h0, 32'h1234_5678);
        feed(0, 32'hA000, we_err, tmo);
        t = model_trig(0, 32'h0, 32'h1234_5678);
        n_checks++; if (tmo || we_err != 0 || stream.size() != DEPTH)
            $display("FAIL mask0_capture: got len %0d werr %0d expected %0d 0", stream.size(), we_err, DEPTH); else n_pass++;
        n_checks++; if (bus.trig_addr !== '0 || t != 0) $display("FAIL mask0_trig_addr: got %0d expected 0", bus.trig_addr); else n_pass++;
        read_window(100, nlast, lidx, serr, cyc, rtmo);
        n_checks++; if (rtmo || window_errs(t, 0) != 0 || rd_q[0] !== 32'hA000)
            $display("FAIL mask0_window: got first %h expected a000", rd_q[0]); else n_pass++;
    endtask

    task automatic test_pre_max();
        int we_err, t, nlast, lidx, serr, cyc; bit tmo, rtmo;
        arm_cap(15, 32'hFFFF_FFFF, 32'h514);
        feed(0, 32'h500, we_err, tmo);
        t = model_trig(15, 32'hFFFF_FFFF, 32'h514);
        n_checks++; if (tmo || we_err != 0 || stream.size() != t + 1)
            $display("FAIL premax_len: got %0d expected %0d", stream.size(), t + 1); else n_pass++;
        read_window(100, nlast, lidx, serr, cyc, rtmo);
        n_checks++; if (rtmo || window_errs(t, 15) != 0 || rd_q[DEPTH-1] !== 32'h514)
            $display("FAIL premax_window: got last %h expected 514", rd_q[rd_q.size()-1]); else n_pass++;
    endtask

    task automatic test_wrap();
        int we_err, t, nlast, lidx, serr, cyc; bit tmo, rtmo;
        arm_cap(5, 32'hFFFF_FFFF, 32'h864);
        feed(1, 32'h800, we_err, tmo);
        t = model_trig(5, 32'hFFFF_FFFF, 32'h864);
        n_checks++; if (tmo || we_err != 0) $display("FAIL wrap_writes: got %0d bad expected 0", we_err); else n_pass++;
        n_checks++; if (t != 50 || bus.trig_addr !== AW'(t % DEPTH)) $display("FAIL wrap_trig_addr: got %0d expected %0d", bus.trig_addr, t % DEPTH); else n_pass++;
        read_window(100, nlast, lidx, serr, cyc, rtmo);
        n_checks++; if (rtmo || window_errs(t, 5) != 0) $display("FAIL wrap_window: got %0d bad words expected 0", window_errs(t, 5)); else n_pass++;
    endtask

    task automatic test_random_ready();
        int we_err, t, pre, nlast, lidx, serr, cyc; bit tmo, rtmo;
        logic [DW-1:0] val;
        for (int it = 0; it < 3; it++) begin
            pre = $urandom_range(0, DEPTH - 1);
            val = DW'($urandom_range(0, 7));
            arm_cap(pre, 32'h7, val);
            feed(2, $urandom & 32'h0FFF_FFF0, we_err, tmo);
            t = model_trig(pre, 32'h7, val);
            n_checks++; if (tmo || we_err != 0 || t < 0 || stream.size() != t + DEPTH - pre)
                $display("FAIL rand_capture: got len %0d werr %0d expected %0d 0", stream.size(), we_err, t + DEPTH - pre); else n_pass++;
            n_checks++; if (bus.trig_addr !== AW'(t % DEPTH)) $display("FAIL rand_trig_addr: got %0d expected %0d", bus.trig_addr, t % DEPTH); else n_pass++;
            read_window(50, nlast, lidx, serr, cyc, rtmo);
            n_checks++; if (rtmo || window_errs(t, pre) != 0) $display("FAIL rand_window: got %0d bad words expected 0", window_errs(t, pre)); else n_pass++;
            n_checks++; if (serr != 0) $display("FAIL rand_stall_stable: got %0d changes expected 0", serr); else n_pass++;
            n_checks++; if (nlast != 1 || lidx != DEPTH - 1) $display("FAIL rand_last: got %0d at %0d expected 1 at %0d", nlast, lidx, DEPTH - 1); else n_pass++;
        end
    endtask

    task automatic test_abort();
        logic [DW-1:0] v;
        bit tmo;
        int wes;
        arm_cap(2, 32'hFFFF_FFFF, 32'h305);
        v = 32'h300; bus.probe = v; v++; bus.sample_en = 1; tmo = 1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.triggered === 1'b1) begin tmo = 0; break; end
            bus.probe = v; v++;
        end
        @(negedge clk); bus.probe = v; v++;
        #1;
        n_checks++; if (tmo || bus.busy !== 1'b1) $display("FAIL abort_in_post: got busy %b expected 1", bus.busy); else n_pass++;
        @(negedge clk); bus.abort = 1;
        @(negedge clk); bus.abort = 0;
        #1;
        n_checks++; if ({bus.busy, bus.triggered, bus.done, bus.ram_we} !== 4'b0)
            $display("FAIL abort_idle: got %b expected 0000", {bus.busy, bus.triggered, bus.done, bus.ram_we}); else n_pass++;
        wes = 0;
        repeat (5) begin @(negedge clk); #1; if (bus.ram_we !== 1'b0) wes++; end
        @(negedge clk);
        bus.arm = 1; bus.abort = 1; bus.pre_trig = '0; bus.trig_mask = '0;
        @(negedge clk); bus.arm = 0; bus.abort = 0;
        repeat (4) begin #1; if (bus.ram_we !== 1'b0 || bus.busy !== 1'b0) wes++; @(negedge clk); end
        n_checks++; if (wes != 0) $display("FAIL abort_no_writes: got %0d writes expected 0", wes); else n_pass++;
        bus.sample_en = 0;
    endtask

    task automatic test_read_abort_reset();
        int we_err; bit tmo;
        arm_cap(0, 32'h0, 32'h0);
        feed(0, 32'h900, we_err, tmo);
        @(negedge clk); bus.rd_start = 1; bus.out_ready = 0;
        @(negedge clk); bus.rd_start = 0;
        repeat (3) @(negedge clk);
        bus.abort = 1;
        @(negedge clk); bus.abort = 0;
        #1;
        n_checks++; if (tmo || bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL read_abort: got valid %b busy %b expected 0 0", bus.out_valid, bus.busy); else n_pass++;
        arm_cap(0, 32'h0, 32'h0);
        feed(0, 32'hB00, we_err, tmo);
        @(negedge clk); bus.rd_start = 1;
        @(negedge clk); bus.rd_start = 0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (tmo || bus.out_valid !== 1'b1 || bus.out_data !== 32'hB00)
            $display("FAIL read_hold: got valid %b data %h expected 1 b00", bus.out_valid, bus.out_data); else n_pass++;
        @(negedge clk); rst = 1;
        @(negedge clk);
        #1;
        n_checks++; if ({bus.busy, bus.done, bus.triggered, bus.ram_we, bus.ram_re, bus.out_valid, bus.out_last, bus.out_data, bus.trig_addr, bus.ram_raddr, bus.ram_waddr} !== '0)
            $display("FAIL reset_mid_read: got busy %b done %b valid %b data %h expected all 0", bus.busy, bus.done, bus.out_valid, bus.out_data); else n_pass++;
        @(negedge clk); rst = 0;
    endtask

    initial begin
        test_reset();
        test_basic_trigger();
        test_back_to_back();
        test_mask_zero();
        test_pre_max();
        test_wrap();
        test_random_ready();
        test_abort();
        test_read_abort_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/cwc_capture_ctrl.md
Name: cwc_capture_ctrl

Overview:
Capture sequencer for the on-chip logic-analyzer sample buffer. It is armed by software, fills a ring buffer with a programmable pre-trigger window, and evaluates a mask/value trigger on the probe word. It then collects the post-trigger samples and plays the whole window back in chronological order over a valid/ready stream. It sits between the probe bus concat, a single-port-write/registered-read sample RAM, and the readout path (UDP debug channel).

Parameters:
DATA_W, 32, probe word width (trigger and RAM data width)
DEPTH, 1024, sample RAM depth; power of two, >= 4
ADDR_W, 10, log2(DEPTH)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
arm  in  1  start capture (pulse)
abort  in  1  cancel capture or readout (pulse)
pre_trig  in  ADDR_W  pre-trigger sample count, latched on arm
trig_mask  in  DATA_W  trigger compare mask, latched on arm
trig_value  in  DATA_W  trigger compare value, latched on arm
sample_en  in  1  probe word valid this cycle
probe  in  DATA_W  probe word
ram_we  out  1  RAM write strobe
ram_waddr  out  ADDR_W  RAM write address
ram_wdata  out  DATA_W  RAM write data
ram_re  out  1  RAM read strobe
ram_raddr  out  ADDR_W  RAM read address
ram_rdata  in  DATA_W  RAM read data, valid cycle after ram_re, held until next ram_re
rd_start  in  1  start readout (pulse, honoured in DONE only)
out_valid  out  1  readout word valid
out_ready  in  1  downstream accepts
out_data  out  DATA_W  readout word (= ram_rdata)
out_last  out  1  final word of window
busy  out  1  state != IDLE and != DONE
triggered  out  1  trigger seen in current capture
done  out  1  state == DONE
trig_addr  out  ADDR_W  RAM address of trigger sample

Behaviour:
- Reset: state IDLE; all outputs 0; write pointer and counters 0.
- States: IDLE, PRE, WAIT_TRIG, POST, DONE, READ.
- abort, any state -> IDLE next cycle; clears triggered. abort has priority over arm and rd_start in the same cycle.
- arm is accepted in IDLE or DONE only; ignored elsewhere. On acceptance:
  - latch pre_trig, clipped to DEPTH-1;
  - latch mask and value;
  - clear triggered;
  - write pointer to 0;
  - go to PRE, or to WAIT_TRIG if the latched pre_trig == 0.
- Writes (PRE, WAIT_TRIG, POST):
  - When sample_en=1: ram_we=1 combinationally, ram_wdata=probe, ram_waddr=wptr.
  - wptr increments modulo DEPTH after each write.
  - No writes in other states.
- PRE: count writes; after the pre_trig-th write, go to WAIT_TRIG. No trigger evaluation in PRE.
- WAIT_TRIG:
  - Each written sample is compared; hit = sample_en && ((probe ^ value) & mask) == 0.
  - Mask 0 triggers on the first sample.
  - On a hit: that sample is written; trig_addr <= wptr; triggered <= 1; go to POST, or to DONE if DEPTH-1-pre_trig == 0.
  - Non-hit samples overwrite the ring, so the pre-window is always the last pre_trig samples before the trigger.
- POST: after DEPTH-1-pre_trig further writes, go to DONE.
  - Total window = DEPTH samples.
  - Window start address = (trig_addr - pre_trig) mod DEPTH.
- DONE + rd_start -> READ:
  - rptr <= start address; word count <= 0.
- READ:
  - ram_re is issued when (!out_valid || out_ready) and words issued < DEPTH; ram_raddr = rptr, which then increments modulo DEPTH.
  - out_valid rises the cycle after ram_re and holds until the handshake.
  - Back-to-back issue gives 1 word/cycle when out_ready is held high.
  - out_data must stay stable while out_valid && !out_ready.
  - out_last=1 on the DEPTH-th word.
  - After the last handshake -> DONE; re-readout is allowed.
- Readout has no effect on the RAM contents. Readout abort drops out_valid next cycle.

Test Plan:
- DEPTH=16. Arm with pre_trig=4, mask=FFFFFFFF, value=0x20, probe=counter 0x10.. every cycle -> trigger on 0x20, triggered=1. Readout yields 16 words 0x1C..0x2B, out_last on 0x2B.
- pre_trig=0, mask=0 -> trigger on the first sample, trig_addr=0. Readout starts at the trigger word; done after 16 samples.
- pre_trig=15 -> DONE the same cycle the trigger sample is written; readout ends with the trigger word.
- sample_en toggling 1/0 with a long pre-trigger wait (ring wraps ~3 times) -> correct start address after wrap. No writes when sample_en=0.
- Readout with out_ready random 50% -> 16 unique in-order words. out_data stable under stall; out_last exactly once.
- abort in POST, and arm+abort in the same cycle -> IDLE next cycle, triggered=0, no further ram_we. rst asserted mid-READ -> all outputs 0.
